// File: rtl/sha_msg_sched_if.sv
// Block-in / schedule-word-out stream bundle for sha_msg_sched.
// slave is the scheduler side; master is the block source plus the word consumer.
interface sha_msg_sched_if;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_data;
  logic [5:0]   w_idx;
  logic         w_last;
  logic [31:0]  k_data;

  modport slave (
    input  blk_valid, blk_data, w_ready,
    output blk_ready, w_valid, w_data, w_idx, w_last, k_data
  );

  modport master (
    output blk_valid, blk_data, w_ready,
    input  blk_ready, w_valid, w_data, w_idx, w_last, k_data
  );
endinterface

// File: rtl/sha_msg_sched.sv
// SHA-256 message schedule: expands one 512-bit block into W[0..63] over a 16-word window.
// SHA_SCHED_KROM_EN adds the K constant ROM on k_data. States: IDLE | waiting for block; RUN | streaming W[t].
module sha_msg_sched (
  input  logic            clk,
  input  logic            reset,
  sha_msg_sched_if.slave  bus
);
  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] r_q [16];
  logic [31:0] r_d [16];
  logic        run;

  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  // The window itself needs no reset: it is reloaded on every block accept.
  always_ff @(posedge clk) begin
    r_q <= r_d;
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        if (bus.blk_valid) begin
          for (int i = 0; i < 16; i++) r_d[i] = bus.blk_data[511-32*i -: 32];
          t_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.w_ready) begin
          if (t_q == 6'd63) begin
            state_d = IDLE;
          end else begin
            for (int i = 0; i < 15; i++) r_d[i] = r_q[i+1];
            r_d[15] = s1(r_q[14]) + r_q[9] + s0(r_q[1]) + r_q[0];
            t_d     = t_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign run           = (state_q == RUN);
  assign bus.blk_ready = (state_q == IDLE) && !reset;
  assign bus.w_valid   = run;
  assign bus.w_data    = run ? r_q[0] : 32'd0;
  assign bus.w_idx     = run ? t_q : 6'd0;
  assign bus.w_last    = run && (t_q == 6'd63);

`ifdef SHA_SCHED_KROM_EN
  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  assign bus.k_data = run ? K_ROM[t_q] : 32'd0;
`else
  assign bus.k_data = 32'd0;
`endif
endmodule

// File: tb/tb_sha_msg_sched.sv
// Scoreboard bench for sha_msg_sched: a full-array software model queues expected words
// at block accept; each word handshake pops and compares.
module tb_sha_msg_sched;
  typedef struct {
    logic [5:0]  idx;
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  sha_msg_sched_if bif();

  sha_msg_sched dut (.clk(clk), .reset(reset), .bus(bif));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t exp_q[$];
  logic [511:0] pend[$];
  int acc_cyc[$];
  logic [31:0] cap [64];
  int vcount;
  int last63_cyc;
  int gap_val;

  logic [511:0] abc_blk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ms0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ms1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic void push_model(input logic [511:0] b);
    logic [31:0] w [64];
    exp_t e;
    for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
    for (int i = 16; i < 64; i++) w[i] = ms1(w[i-2]) + w[i-7] + ms0(w[i-15]) + w[i-16];
    for (int i = 0; i < 64; i++) begin
      e.idx = 6'(i); e.data = w[i]; e.last = (i == 63);
      exp_q.push_back(e);
    end
  endfunction

  // mode 0: w_ready held high; mode 1: random w_ready. stop_idx>=0 returns when that index is shown.
  task automatic run_stream(input int mode, input int stop_idx, input int budget);
    logic        prev_stall;
    logic [31:0] pd, pk;
    logic [5:0]  pi;
    logic        pl;
    exp_t        e;
    bit          done;
    prev_stall = 0; pd = '0; pk = '0; pi = '0; pl = 0;
    vcount = 0; last63_cyc = -1; gap_val = -1; done = 0;
    acc_cyc.delete();
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      cyc++;
      bif.w_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (pend.size() > 0) begin
        bif.blk_valid = 1'b1;
        bif.blk_data  = pend[0];
      end else begin
        bif.blk_valid = 1'b0;
      end
      #1;
      if (bif.blk_valid && bif.blk_ready) begin
        push_model(pend[0]);
        void'(pend.pop_front());
        acc_cyc.push_back(cyc);
      end
      if (prev_stall) begin
        checks++;
        if (bif.w_data !== pd || bif.w_idx !== pi || bif.w_last !== pl || bif.k_data !== pk) begin
          failures++;
          $display("FAIL stall_hold: got idx=%0d data=%h last=%b k=%h, held idx=%0d data=%h last=%b k=%h",
                   bif.w_idx, bif.w_data, bif.w_last, bif.k_data, pi, pd, pl, pk);
        end
      end
      prev_stall = 0;
      if (bif.w_valid) begin
        vcount++;
        if (bif.w_idx == 6'd0 && last63_cyc >= 0) begin
          gap_val = cyc - last63_cyc;
          last63_cyc = -1;
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word: idx=%0d data=%h with empty scoreboard", bif.w_idx, bif.w_data);
        end else begin
          e = exp_q[0];
          if (bif.w_data !== e.data || bif.w_idx !== e.idx || bif.w_last !== e.last) begin
            failures++;
            $display("FAIL word: got idx=%0d data=%h last=%b, want idx=%0d data=%h last=%b",
                     bif.w_idx, bif.w_data, bif.w_last, e.idx, e.data, e.last);
          end
`ifdef SHA_SCHED_KROM_EN
          if (e.idx == 6'd0 || e.idx == 6'd63) begin
            checks++;
            if (bif.k_data !== ((e.idx == 6'd0) ? 32'h428A2F98 : 32'hC67178F2)) begin
              failures++;
              $display("FAIL k_data: idx=%0d got %h", e.idx, bif.k_data);
            end
          end
`else
          checks++;
          if (bif.k_data !== 32'd0) begin
            failures++;
            $display("FAIL k_data_zero: idx=%0d got %h want 0", e.idx, bif.k_data);
          end
`endif
          if (bif.w_ready) begin
            cap[e.idx] = bif.w_data;
            if (e.idx == 6'd63) last63_cyc = cyc;
            void'(exp_q.pop_front());
          end else begin
            prev_stall = 1;
            pd = bif.w_data; pi = bif.w_idx; pl = bif.w_last; pk = bif.k_data;
          end
        end
        if (stop_idx >= 0 && int'(bif.w_idx) == stop_idx) done = 1;
      end
      if (stop_idx < 0 && pend.size() == 0 && exp_q.size() == 0) done = 1;
    end
    bif.blk_valid = 1'b0;
    if (!done) begin
      failures++;
      $display("FAIL timeout: stream incomplete, %0d words left, %0d blocks pending", exp_q.size(), pend.size());
      exp_q.delete();
      pend.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bif.blk_ready !== 1'b0 || bif.w_valid !== 1'b0 || bif.w_idx !== 6'd0 ||
        bif.w_data !== 32'd0 || bif.w_last !== 1'b0 || bif.k_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: rdy=%b v=%b idx=%0d data=%h last=%b k=%h, want all 0",
               bif.blk_ready, bif.w_valid, bif.w_idx, bif.w_data, bif.w_last, bif.k_data);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bif.blk_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: blk_ready=%b want 1", bif.blk_ready);
    end
  endtask

  task automatic test_abc();
    pend.push_back(abc_blk);
    run_stream(0, -1, 200);
    checks++;
    if (cap[0] !== 32'h61626380 || cap[15] !== 32'h00000018 ||
        cap[16] !== 32'h61626380 || cap[17] !== 32'h000F0000) begin
      failures++;
      $display("FAIL abc_known: W0=%h W15=%h W16=%h W17=%h want 61626380 00000018 61626380 000f0000",
               cap[0], cap[15], cap[16], cap[17]);
    end
  endtask

  task automatic test_zero();
    pend.push_back(512'd0);
    run_stream(0, -1, 200);
    checks++;
    if (vcount != 64) begin
      failures++;
      $display("FAIL zero_valid_cycles: got %0d want 64", vcount);
    end
  endtask

  task automatic test_backpressure();
    pend.push_back(abc_blk);
    run_stream(1, -1, 1000);
  endtask

  task automatic test_reset_mid();
    logic [511:0] b;
    pend.push_back(abc_blk);
    run_stream(0, 20, 200);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bif.w_valid !== 1'b0 || bif.blk_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid: w_valid=%b blk_ready=%b want 0 1", bif.w_valid, bif.blk_ready);
    end
    for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom;
    pend.push_back(b);
    run_stream(0, -1, 200);
    checks++;
    if (cap[0] !== b[511:480]) begin
      failures++;
      $display("FAIL reset_restart_w0: got %h want %h", cap[0], b[511:480]);
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom;
    pend.push_back(abc_blk);
    pend.push_back(b);
    run_stream(0, -1, 400);
    checks++;
    if (acc_cyc.size() != 2 || (acc_cyc[1] - acc_cyc[0]) != 65) begin
      failures++;
      $display("FAIL b2b_period: accepts=%0d period=%0d want 2 65", acc_cyc.size(),
               (acc_cyc.size() == 2) ? acc_cyc[1] - acc_cyc[0] : -1);
    end
    checks++;
    if (gap_val != 2) begin
      failures++;
      $display("FAIL b2b_gap: W63->W0 gap=%0d want 2", gap_val);
    end
  endtask

  initial begin
    abc_blk = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[31:0]    = 32'h00000018;
    bif.blk_valid = 1'b0;
    bif.blk_data  = '0;
    bif.w_ready   = 1'b0;
    test_reset();
    test_abc();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sha_msg_sched.md
# sha_msg_sched

SHA-256 message schedule generator for the bitcoin miner datapath. It accepts one 512-bit message block and expands it into the 64 schedule words W[0]..W[63]. Words are emitted one per cycle over a valid/ready stream that feeds the round engine. Only a 16-word sliding window is held, so the full 2048-bit W array is never stored.

## Interface
Parameters:
- none. Word width is 32 bits (`WORD_S` from sha.vh). Block width is 512 bits.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- blk_valid  in  1  blk_data holds a block to expand.
- blk_ready  out  1  module can accept a block; equals (state==IDLE) && !reset.
- blk_data  in  512  message block, big-endian; W[0] = blk_data[511:480], W[15] = blk_data[31:0].
- w_valid  out  1  w_data/w_idx hold a schedule word.
- w_ready  in  1  consumer accepts the word.
- w_data  out  32  schedule word W[w_idx].
- w_idx  out  6  index t of the current word, 0..63.
- w_last  out  1  high with w_valid when w_idx==63.
- k_data  out  32  round constant K[w_idx]; present only with SHA_SCHED_KROM_EN.

## Operation
- State is r[0..15], 32-bit words, with r[0] = W[t]. There is also a 6-bit counter t and a state flag with values IDLE/RUN.
- IDLE:
  - On blk_valid && blk_ready: r[i] <= blk_data[511-32i -: 32], t <= 0, go to RUN.
- RUN:
  - w_valid=1, w_data=r[0], w_idx=t, w_last=(t==63).
  - On w_valid && w_ready with t<63: r[i] <= r[i+1] for i in 0..14; r[15] <= s1(r[14]) + r[9] + s0(r[1]) + r[0]; t <= t+1.
  - On w_valid && w_ready with t==63: go to IDLE. r is don't-care from then on.
- Functions:
  - s0(x) = rotr7(x) ^ rotr18(x) ^ shr3(x).
  - s1(x) = rotr17(x) ^ rotr19(x) ^ shr10(x).
  - All additions are modulo 2^32; carries are discarded.
- Words 16..63 are generated lazily, one per accepted handshake.
- Without backpressure, no word is computed ahead.
- blk_valid is ignored in RUN. The upstream source must hold blk_data until the handshake completes.

## Timing
- Reset values: w_valid=0, w_last=0, w_idx=0, w_data=0, k_data=0, t=0, state=IDLE.
- blk_ready is 0 while reset is high and 1 in the first cycle after reset.
- Latency: block accepted on edge N; W[0] is valid in the cycle after edge N.
- Throughput: with w_ready held high, one word per cycle, 64 cycles per block.
- blk_ready rises in the cycle after the W[63] handshake, so the block period is 65 cycles.
- Backpressure: while w_valid && !w_ready, the following are held stable: w_data, w_idx, w_last, k_data, and r.
- w_valid never drops without a handshake, except on reset.
- Reset mid-RUN has the same effect as reset from IDLE:
  - it aborts the block;
  - w_valid=0 from the next cycle;
  - no partial words appear afterwards.
- blk_valid asserted in the same cycle as the final W[63] handshake is not accepted. It is accepted in the following cycle.

## Configuration
- SHA_SCHED_KROM_EN:
  - Defined: includes a 64x32 ROM holding the FIPS 180-4 K constants.
  - k_data = K[w_idx], aligned with w_data and held under backpressure.
  - Defined: the round engine takes K from this stream.
  - Undefined: no ROM is built and k_data is tied to 0.
  - Undefined: the round engine takes K from its own constant bus.

## Test plan
- "abc" padded block (0x61626380, then 14 zero words, then 0x00000018), w_ready=1:
  - W[0]=0x61626380, W[15]=0x00000018, W[16]=0x61626380, W[17]=0x000F0000.
  - w_last only at idx 63.
  - All 64 words match the software model.
- All-zero block: 64 words, all 0x00000000. w_idx runs 0..63 consecutively and w_valid is high for exactly 64 cycles.
- Backpressure: "abc" block with w_ready toggled by a random pattern. w_data/w_idx stay stable during stalls, the sequence matches the model, and there are no skipped or duplicated indices.
- Reset at w_idx=20 while w_ready=1:
  - w_valid=0 and blk_ready=1 in the cycle after reset deasserts.
  - The next block restarts at w_idx=0 with its own W[0].
- Back-to-back blocks with blk_valid held high:
  - blk_ready pulses once per 65 cycles.
  - The second block's W[0] follows the first block's W[63] by exactly 2 cycles.
- SHA_SCHED_KROM_EN defined:
  - k_data=0x428A2F98 with idx 0 and 0xC67178F2 with idx 63.
  - Undefined: k_data=0 throughout.
